// File: rtl/core_stage_ctrl_if.sv
// Handshake and strobe bundle between the NPC stage sequencer and the
// IFU/IDU/EXU/LSU datapath plus the simulation harness status lines.
// The master side is the sequencer; the slave side is the datapath/harness.
interface core_stage_ctrl_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 ifu_req;
  logic                 ifu_valid;
  logic                 idu_en;
  logic                 exu_en;
  logic                 is_mem;
  logic                 is_halt;
  logic                 wb_en;
  logic                 lsu_req;
  logic                 lsu_done;
  logic                 rf_wen;
  logic                 pc_update;
  logic                 busy;
  logic                 halted;
  logic                 wdt_timeout;
  logic [CNT_WIDTH-1:0] retire_cnt;

  modport master (
    output ifu_req, idu_en, exu_en, lsu_req, rf_wen, pc_update,
           busy, halted, wdt_timeout, retire_cnt,
    input  ifu_valid, is_mem, is_halt, wb_en, lsu_done
  );

  modport slave (
    input  ifu_req, idu_en, exu_en, lsu_req, rf_wen, pc_update,
           busy, halted, wdt_timeout, retire_cnt,
    output ifu_valid, is_mem, is_halt, wb_en, lsu_done
  );
endinterface

// File: rtl/core_stage_ctrl.sv
// Multi-cycle sequencer for the NPC core: IDLE -> FETCH -> DECODE -> EXEC
// -> (MEM) -> WB -> FETCH, with absorbing HALT (ebreak) and ERR states.
// All outputs are decoded from the registered state; rf_wen additionally
// gates with wb_en while in WB.
// Optional wait watchdog: define CORE_STAGE_CTRL_WDT_EN to enable a
// FETCH/MEM wait counter that forces ERR after WDT_LIMIT unacked cycles.
module core_stage_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int WDT_LIMIT = 256
) (
  input logic               clk,
  input logic               rst,
  core_stage_ctrl_if.master ctrl_io
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  // A zero limit would trap every fetch immediately, so refuse to build it.
  if (WDT_LIMIT < 1) begin : gLimitCheck
    $error("core_stage_ctrl: WDT_LIMIT must be at least 1");
  end

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] retireCnt_q, retireCnt_d;
  logic                 waitTimeout;

`ifdef CORE_STAGE_CTRL_WDT_EN
  localparam int                WDT_W   = $clog2(WDT_LIMIT + 1);
  localparam logic [WDT_W-1:0]  WDT_MAX = WDT_W'(WDT_LIMIT);

  logic [WDT_W-1:0] wdtCnt_q, wdtCnt_d;

  assign waitTimeout = (wdtCnt_q == WDT_MAX);

  // Count consecutive unacked cycles spent waiting in FETCH or MEM; any state change restarts at zero.
  always_comb begin
    wdtCnt_d = '0;
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
      wdtCnt_d = wdtCnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdtCnt_q <= '0;
    end else begin
      wdtCnt_q <= wdtCnt_d;
    end
  end
`else
  assign waitTimeout = 1'b0;
`endif

  // Stage sequencing; the timeout check sits ahead of the ack so a late ack cannot rescue a timed-out wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (waitTimeout) begin
          state_d = S_ERR;
        end else if (ctrl_io.ifu_valid) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (ctrl_io.is_halt) begin
          state_d = S_HALT;
        end else if (ctrl_io.is_mem) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (waitTimeout) begin
          state_d = S_ERR;
        end else if (ctrl_io.lsu_done) begin
          state_d = S_WB;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_IDLE;
    endcase
  end

  // Retire counter bumps on the edge leaving WB and wraps naturally; the halting ebreak never reaches WB.
  always_comb begin
    retireCnt_d = retireCnt_q;
    if (state_q == S_WB) begin
      retireCnt_d = retireCnt_q + 1'b1;
    end
  end

  // State and retire counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      retireCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retireCnt_q <= retireCnt_d;
    end
  end

  assign ctrl_io.ifu_req    = (state_q == S_FETCH);
  assign ctrl_io.idu_en     = (state_q == S_DECODE);
  assign ctrl_io.exu_en     = (state_q == S_EXEC);
  assign ctrl_io.lsu_req    = (state_q == S_MEM);
  assign ctrl_io.pc_update  = (state_q == S_WB);
  assign ctrl_io.rf_wen     = (state_q == S_WB) && ctrl_io.wb_en;
  assign ctrl_io.busy       = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);
  assign ctrl_io.halted     = (state_q == S_HALT) || (state_q == S_ERR);
  assign ctrl_io.retire_cnt = retireCnt_q;

`ifdef CORE_STAGE_CTRL_WDT_EN
  assign ctrl_io.wdt_timeout = (state_q == S_ERR);
`else
  assign ctrl_io.wdt_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_core_stage_ctrl.sv
// Testbench for core_stage_ctrl. Each instruction is described by its
// fetch wait, memory use, memory wait, wb_en and halt flag; a planner turns
// that description into a per-cycle list of inputs and expected outputs,
// with unconstrained inputs randomized to show they are ignored.
module tb_core_stage_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int WDT_LIM = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  core_stage_ctrl_if #(.CNT_WIDTH(CNT_W)) bus_if ();

  core_stage_ctrl #(
    .CNT_WIDTH(CNT_W),
    .WDT_LIMIT(WDT_LIM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus_if.master)
  );

  always #5 clk = ~clk;

  // Expected vector bit order: ifu_req idu_en exu_en lsu_req rf_wen pc_update busy halted wdt_timeout
  typedef struct {
    bit             rst;
    bit             ifuValid;
    bit             lsuDone;
    bit             isMem;
    bit             isHalt;
    bit             wbEn;
    logic [8:0]     expVec;
    logic [CNT_W-1:0] expCnt;
  } cycRec_t;

  cycRec_t          plan[$];
  logic [8:0]       obsVec[$];
  logic [CNT_W-1:0] obsCnt[$];
  int               modelCnt;

  localparam logic [8:0] V_IDLE  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_FETCH = 9'b1_0_0_0_0_0_1_0_0;
  localparam logic [8:0] V_DEC   = 9'b0_1_0_0_0_0_1_0_0;
  localparam logic [8:0] V_EXEC  = 9'b0_0_1_0_0_0_1_0_0;
  localparam logic [8:0] V_MEM   = 9'b0_0_0_1_0_0_1_0_0;
  localparam logic [8:0] V_HALT  = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] V_ERR   = 9'b0_0_0_0_0_0_0_1_1;

  function automatic bit rb();
    return bit'($urandom_range(1, 0));
  endfunction

  function automatic logic [8:0] wbVec(bit we);
    return {4'b0000, we, 1'b1, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic logic [8:0] curVec();
    return {bus_if.ifu_req, bus_if.idu_en, bus_if.exu_en, bus_if.lsu_req, bus_if.rf_wen,
            bus_if.pc_update, bus_if.busy, bus_if.halted, bus_if.wdt_timeout};
  endfunction

  task automatic push(input bit r, input bit iv, input bit ld, input bit im, input bit ih,
                      input bit we, input logic [8:0] v);
    plan.push_back('{rst: r, ifuValid: iv, lsuDone: ld, isMem: im, isHalt: ih, wbEn: we,
                     expVec: v, expCnt: CNT_W'(modelCnt)});
  endtask

  task automatic plan_idle();
    push(1'b0, rb(), rb(), rb(), rb(), rb(), V_IDLE);
  endtask

  // One instruction's worth of cycles; abortMem asserts rst in the first MEM cycle instead of finishing.
  task automatic plan_instr(input int fwait, input bit mem, input int mwait, input bit wbe,
                            input bit halt, input bit abortMem);
    for (int i = 0; i < fwait; i++) push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
    push(1'b0, 1'b1, rb(), rb(), rb(), rb(), V_FETCH);
    push(1'b0, rb(), rb(), rb(), rb(), rb(), V_DEC);
    push(1'b0, rb(), rb(), mem, halt, rb(), V_EXEC);
    if (halt) return;
    if (mem) begin
      if (abortMem) begin
        push(1'b1, rb(), 1'b0, rb(), rb(), rb(), V_MEM);
        modelCnt = 0;
        return;
      end
      for (int i = 0; i < mwait; i++) push(1'b0, rb(), 1'b0, rb(), rb(), rb(), V_MEM);
      push(1'b0, rb(), 1'b1, rb(), rb(), rb(), V_MEM);
    end
    push(1'b0, rb(), rb(), rb(), rb(), wbe, wbVec(wbe));
    modelCnt = (modelCnt + 1) % CNT_MOD;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    modelCnt = 0;
    plan.delete();
  endtask

  // Plays the plan cycle by cycle and records outputs at the falling edge.
  task automatic drive_plan();
    obsVec.delete();
    obsCnt.delete();
    foreach (plan[i]) begin
      rst              = plan[i].rst;
      bus_if.ifu_valid = plan[i].ifuValid;
      bus_if.lsu_done  = plan[i].lsuDone;
      bus_if.is_mem    = plan[i].isMem;
      bus_if.is_halt   = plan[i].isHalt;
      bus_if.wb_en     = plan[i].wbEn;
      @(negedge clk);
      obsVec.push_back(curVec());
      obsCnt.push_back(bus_if.retire_cnt);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.ifu_valid = 1'b1;
    bus_if.lsu_done  = 1'b1;
    bus_if.is_mem    = 1'b1;
    bus_if.is_halt   = 1'b0;
    bus_if.wb_en     = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus_if.ifu_valid = rb();
      bus_if.lsu_done  = rb();
      @(negedge clk);
      checks += 2;
      if (curVec() !== V_IDLE) begin
        errors++;
        $display("[TB] FAIL reset_outputs cycle %0d: got %b expected %b", i, curVec(), V_IDLE);
      end
      if (bus_if.retire_cnt !== '0) begin
        errors++;
        $display("[TB] FAIL reset_cnt cycle %0d: got %0d expected 0", i, bus_if.retire_cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    do_reset();
    plan_idle();
    plan_instr(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
    drive_plan();
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL alu_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL alu_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
    end
    checks += 2;
    if ({obsVec[0][8], obsVec[1][8], obsVec[2][7], obsVec[3][6]} !== 4'b0111) begin
      errors++;
      $display("[TB] FAIL alu_strobe_timing: got %b expected 0111",
               {obsVec[0][8], obsVec[1][8], obsVec[2][7], obsVec[3][6]});
    end
    if ({obsVec[4][4], obsVec[4][3], obsCnt[5]} !== {2'b11, CNT_W'(1)}) begin
      errors++;
      $display("[TB] FAIL alu_commit: got rf=%b pc=%b cnt=%0d expected rf=1 pc=1 cnt=1",
               obsVec[4][4], obsVec[4][3], obsCnt[5]);
    end
  endtask

  task automatic test_mem();
    int lsuCycles;
    do_reset();
    plan_idle();
    plan_instr(1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
    drive_plan();
    lsuCycles = 0;
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL mem_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL mem_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
      if (obsVec[i][5] === 1'b1) lsuCycles++;
    end
    checks++;
    if (lsuCycles != 4) begin
      errors++;
      $display("[TB] FAIL mem_lsu_req_len: got %0d cycles expected 4", lsuCycles);
    end
  endtask

  task automatic test_halt();
    int last;
    do_reset();
    plan_idle();
    plan_instr(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    plan_instr(1, 1'b1, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) push(1'b0, (i == 2), rb(), rb(), rb(), rb(), V_HALT);
    drive_plan();
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL halt_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL halt_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
    end
    last = obsVec.size() - 1;
    checks++;
    if ({obsVec[last][1], obsVec[last][2], obsCnt[last]} !== {2'b10, CNT_W'(1)}) begin
      errors++;
      $display("[TB] FAIL halt_final: got halted=%b busy=%b cnt=%0d expected halted=1 busy=0 cnt=1",
               obsVec[last][1], obsVec[last][2], obsCnt[last]);
    end
  endtask

  task automatic test_mid_reset();
    int rstIdx;
    do_reset();
    plan_idle();
    plan_instr(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    plan_instr(0, 1'b1, 0, 1'b1, 1'b0, 1'b1);
    rstIdx = plan.size();
    plan_idle();
    plan_instr(0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
    drive_plan();
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL midrst_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL midrst_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
    end
    checks++;
    if ({obsVec[rstIdx], obsCnt[rstIdx]} !== {V_IDLE, CNT_W'(0)}) begin
      errors++;
      $display("[TB] FAIL midrst_after: got vec=%b cnt=%0d expected vec=%b cnt=0",
               obsVec[rstIdx], obsCnt[rstIdx], V_IDLE);
    end
  endtask

  task automatic test_wrap();
    int last;
    do_reset();
    plan_idle();
    for (int n = 0; n < 17; n++)
      plan_instr($urandom_range(5, 0), rb(), $urandom_range(5, 0), rb(), 1'b0, 1'b0);
    push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
    drive_plan();
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL wrap_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL wrap_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
    end
    last = obsCnt.size() - 1;
    checks++;
    if (obsCnt[last] !== CNT_W'(1)) begin
      errors++;
      $display("[TB] FAIL wrap_final: got %0d expected 1", obsCnt[last]);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    plan_idle();
    for (int n = 0; n < 10; n++)
      plan_instr((n < 5) ? 0 : $urandom_range(3, 0), rb(), $urandom_range(3, 0), rb(), 1'b0, 1'b0);
    plan_instr(0, rb(), 0, rb(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(1'b0, rb(), rb(), rb(), rb(), rb(), V_HALT);
    drive_plan();
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL b2b_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL b2b_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
    end
  endtask

  task automatic test_watchdog();
    int last;
    do_reset();
    plan_idle();
`ifdef CORE_STAGE_CTRL_WDT_EN
    for (int i = 0; i < WDT_LIM; i++) push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
    push(1'b0, 1'b1, rb(), rb(), rb(), rb(), V_FETCH);
    for (int i = 0; i < 4; i++) push(1'b0, rb(), rb(), rb(), rb(), rb(), V_ERR);
`else
    for (int i = 0; i < 999; i++) push(1'b0, 1'b0, rb(), rb(), rb(), rb(), V_FETCH);
`endif
    drive_plan();
    foreach (plan[i]) begin
      checks += 2;
      if (obsVec[i] !== plan[i].expVec) begin
        errors++;
        $display("[TB] FAIL wdt_vec cycle %0d: got %b expected %b", i + 1, obsVec[i], plan[i].expVec);
      end
      if (obsCnt[i] !== plan[i].expCnt) begin
        errors++;
        $display("[TB] FAIL wdt_cnt cycle %0d: got %0d expected %0d", i + 1, obsCnt[i], plan[i].expCnt);
      end
    end
    last = obsVec.size() - 1;
    checks++;
`ifdef CORE_STAGE_CTRL_WDT_EN
    if ({obsVec[last][1], obsVec[last][0]} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL wdt_err: got halted=%b wdt_timeout=%b expected 1 1",
               obsVec[last][1], obsVec[last][0]);
    end
`else
    if ({obsVec[last][8], obsVec[last][0]} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL wdt_off_cycle1000: got ifu_req=%b wdt_timeout=%b expected 1 0",
               obsVec[last][8], obsVec[last][0]);
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    $display("[TB] core_stage_ctrl bench start");
    test_reset();
    test_alu();
    test_mem();
    test_halt();
    test_mid_reset();
    test_wrap();
    test_back_to_back();
    test_watchdog();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
